// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - imem, redirect and decode-side signals of the fetch unit
interface fetch_unit_if;
  logic [31:0] imem_addr;
  logic        imem_en;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_instr;

  modport master (
    output imem_addr, imem_en, id_valid, id_pc, id_instr,
    input  imem_rdata, redirect_valid, redirect_pc, id_ready
  );

  modport slave (
    input  imem_addr, imem_en, id_valid, id_pc, id_instr,
    output imem_rdata, redirect_valid, redirect_pc, id_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch PC, {pc, instr} buffer and redirect; FETCH_PERF_CNT_EN adds perf counters
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              system_ena,
  fetch_unit_if.master      bus,
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_stall_cnt
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [31:0] pc_q, pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0] buf_pc_q [DEPTH];
  logic [31:0] buf_pc_d [DEPTH];
  logic [31:0] buf_instr_q [DEPTH];
  logic [31:0] buf_instr_d [DEPTH];

  logic active;
  logic redirect;
  logic pop;
  logic push;
  logic can_push;

  // Handshake decode: reset and redirect both suppress fetch and presentation
  always_comb begin
    active   = ~reset & system_ena & ~bus.redirect_valid;
    redirect = system_ena & bus.redirect_valid;
    bus.id_valid = active & (count_q != '0);
    pop      = bus.id_valid & bus.id_ready;
    can_push = (count_q < CW'(DEPTH)) | pop;
    push     = active & can_push;
    bus.imem_en   = push;
    bus.imem_addr = pc_q;
    bus.id_pc     = buf_pc_q[rd_ptr_q];
    bus.id_instr  = buf_instr_q[rd_ptr_q];
  end

  // Next-state for PC, occupancy and pointers; redirect overrides push/pop
  always_comb begin
    pc_d     = pc_q;
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (redirect) begin
      pc_d     = bus.redirect_pc & ~32'h3;
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (push) begin
        pc_d     = pc_q + 32'd4;
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Buffer storage write on push
  always_comb begin
    buf_pc_d    = buf_pc_q;
    buf_instr_d = buf_instr_q;
    if (push) begin
      buf_pc_d[wr_ptr_q]    = pc_q;
      buf_instr_d[wr_ptr_q] = bus.imem_rdata;
    end
  end

  // Control state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q     <= RESET_PC;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      pc_q     <= pc_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // Buffer storage registers; contents are don't-care while empty
  always_ff @(posedge clk) begin
    buf_pc_q    <= buf_pc_d;
    buf_instr_q <= buf_instr_d;
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_q, perf_fetch_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  // Counter increments; redirect does not clear them
  always_comb begin
    perf_fetch_d = perf_fetch_q;
    perf_stall_d = perf_stall_q;
    if (push) begin
      perf_fetch_d = perf_fetch_q + 32'd1;
    end
    if (active & ~can_push) begin
      perf_stall_d = perf_stall_q + 32'd1;
    end
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetch_q <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_fetch_q <= perf_fetch_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_fetch_cnt = perf_fetch_q;
  assign perf_stall_cnt = perf_stall_q;
`else
  assign perf_fetch_cnt = 32'd0;
  assign perf_stall_cnt = 32'd0;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic        system_ena;
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
  int          vectors = 0;
  int          errors  = 0;

  fetch_unit_if bus();

  fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk            (clk),
    .reset          (reset),
    .system_ena     (system_ena),
    .bus            (bus),
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
  );

  always #5 clk = ~clk;

  assign bus.imem_rdata = 32'h1000_0000 + (bus.imem_addr >> 2);

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return 32'h1000_0000 + (a >> 2);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk_pres(input string tag, input logic [31:0] pc);
    chk({tag, "_valid"}, {31'd0, bus.id_valid}, 32'd1);
    chk({tag, "_pc"}, bus.id_pc, pc);
    chk({tag, "_instr"}, bus.id_instr, word_at(pc));
  endtask

  logic [31:0] exp_stall;
  logic [31:0] exp_fetch;

  initial begin
    reset = 1'b1;
    system_ena = 1'b1;
    bus.id_ready = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 32'h0;
    tick();
    tick();
    settle();
    chk("rst_valid", {31'd0, bus.id_valid}, 32'd0);
    chk("rst_en", {31'd0, bus.imem_en}, 32'd0);
    chk("rst_addr", bus.imem_addr, 32'h0);
    chk("rst_pfetch", perf_fetch_cnt, 32'd0);
    chk("rst_pstall", perf_stall_cnt, 32'd0);

    // streaming from reset, decode always ready
    reset = 1'b0;
    settle();
    chk("s0_addr", bus.imem_addr, 32'h0);
    chk("s0_en", {31'd0, bus.imem_en}, 32'd1);
    chk("s0_valid", {31'd0, bus.id_valid}, 32'd0);
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk_pres("stream", 32'(4 * (k - 1)));
      chk("stream_addr", bus.imem_addr, 32'(4 * k));
      chk("stream_en", {31'd0, bus.imem_en}, 32'd1);
    end

    // stall: decode not ready for 5 cycles after a fresh reset
    reset = 1'b1;
    bus.id_ready = 1'b0;
    tick();
    reset = 1'b0;
    settle();
    chk("st0_en", {31'd0, bus.imem_en}, 32'd1);
    chk("st0_valid", {31'd0, bus.id_valid}, 32'd0);
    tick();
    chk("st1_addr", bus.imem_addr, 32'h4);
    chk_pres("st1", 32'h0);
    for (int k = 2; k <= 4; k++) begin
      tick();
      chk("stall_addr", bus.imem_addr, 32'h8);
      chk("stall_en", {31'd0, bus.imem_en}, 32'd0);
      chk_pres("stall", 32'h0);
    end
    tick();
`ifdef FETCH_PERF_CNT_EN
    exp_stall = 32'd3;
    exp_fetch = 32'd2;
`else
    exp_stall = 32'd0;
    exp_fetch = 32'd0;
`endif
    chk("perf_stall", perf_stall_cnt, exp_stall);
    chk("perf_fetch", perf_fetch_cnt, exp_fetch);

    // release: pass-through while full
    bus.id_ready = 1'b1;
    settle();
    chk_pres("rel0", 32'h0);
    chk("rel0_en", {31'd0, bus.imem_en}, 32'd1);
    chk("rel0_addr", bus.imem_addr, 32'h8);
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk_pres("pass", 32'(4 * k));
      chk("pass_addr", bus.imem_addr, 32'(8 + 4 * k));
      chk("pass_en", {31'd0, bus.imem_en}, 32'd1);
    end

    // redirect with two entries buffered
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h0000_0103;
    settle();
    chk("rdN_valid", {31'd0, bus.id_valid}, 32'd0);
    chk("rdN_en", {31'd0, bus.imem_en}, 32'd0);
    tick();
    bus.redirect_valid = 1'b0;
    settle();
    chk("rdN1_addr", bus.imem_addr, 32'h100);
    chk("rdN1_valid", {31'd0, bus.id_valid}, 32'd0);
    chk("rdN1_en", {31'd0, bus.imem_en}, 32'd1);
    tick();
    chk_pres("rdN2", 32'h100);
    tick();
    chk_pres("rdN3", 32'h104);

    // back-to-back redirects: the last one wins
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h0000_0200;
    tick();
    bus.redirect_pc = 32'h0000_0300;
    settle();
    chk("bb1_addr", bus.imem_addr, 32'h200);
    chk("bb1_valid", {31'd0, bus.id_valid}, 32'd0);
    tick();
    bus.redirect_valid = 1'b0;
    settle();
    chk("bb2_addr", bus.imem_addr, 32'h300);
    chk("bb2_valid", {31'd0, bus.id_valid}, 32'd0);
    tick();
    chk_pres("bb3", 32'h300);
    chk("bb3_addr", bus.imem_addr, 32'h304);

    // freeze for 3 cycles with an ignored redirect in the middle
    system_ena = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus.redirect_valid = (k == 1);
      bus.redirect_pc = 32'h0000_0500;
      settle();
      chk("frz_valid", {31'd0, bus.id_valid}, 32'd0);
      chk("frz_en", {31'd0, bus.imem_en}, 32'd0);
      chk("frz_addr", bus.imem_addr, 32'h304);
      tick();
    end
    bus.redirect_valid = 1'b0;
    system_ena = 1'b1;
    settle();
    chk_pres("res0", 32'h300);
    chk("res0_addr", bus.imem_addr, 32'h304);
    tick();
    chk_pres("res1", 32'h304);
    chk("res1_addr", bus.imem_addr, 32'h308);

    // fill the buffer, then reset while full
    bus.id_ready = 1'b0;
    tick();
    chk("full_en", {31'd0, bus.imem_en}, 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    settle();
    chk("post_rst_valid", {31'd0, bus.id_valid}, 32'd0);
    chk("post_rst_addr", bus.imem_addr, 32'h0);
    chk("post_rst_pfetch", perf_fetch_cnt, 32'd0);
    tick();

    // PC wrap through the top of the address space
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFF9;
    settle();
    chk("wr_rd_valid", {31'd0, bus.id_valid}, 32'd0);
    tick();
    bus.redirect_valid = 1'b0;
    bus.id_ready = 1'b1;
    settle();
    chk("wr0_addr", bus.imem_addr, 32'hFFFF_FFF8);
    chk("wr0_valid", {31'd0, bus.id_valid}, 32'd0);
    tick();
    chk_pres("wr1", 32'hFFFF_FFF8);
    chk("wr1_addr", bus.imem_addr, 32'hFFFF_FFFC);
    tick();
    chk_pres("wr2", 32'hFFFF_FFFC);
    chk("wr2_addr", bus.imem_addr, 32'h0);
    tick();
    chk_pres("wr3", 32'h0);
    chk("wr3_addr", bus.imem_addr, 32'h4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch front end of core0, directly upstream of the decode stage that feeds id_exe_reg_inst.
- Owns the architectural fetch PC and addresses imem_inst. imem_inst is asynchronous read: data returns in the same cycle as the address.
- Buffers fetched {pc, instr} pairs in a small FIFO and presents them to decode with a valid/ready handshake.
- Accepts PC redirects (branch/jump resolved in EX) and flushes everything fetched down the wrong path.

Parameters:
- RESET_PC, 32'h0000_0000, fetch PC loaded on reset; bits [1:0] must be 0.
- DEPTH, 2, fetch-buffer entries; power of 2, minimum 2.

Ports:
- clk  in  1  core clock, all state updates on the rising edge.
- reset  in  1  synchronous, active-high; one clock edge with it high fully initialises the block.
- system_ena  in  1  global enable; 0 freezes the block.
- imem_addr  out  32  byte address to imem; always equals the current fetch PC.
- imem_en  out  1  a fetch is being accepted this cycle.
- imem_rdata  in  32  instruction word at imem_addr, valid in the same cycle.
- redirect_valid  in  1  EX requests a PC change.
- redirect_pc  in  32  new fetch PC; bits [1:0] are ignored and treated as 0.
- id_valid  out  1  head entry is presented to decode.
- id_ready  in  1  decode accepts the head entry this cycle.
- id_pc  out  32  PC of the head entry.
- id_instr  out  32  instruction of the head entry.
- perf_fetch_cnt  out  32  fetched-instruction counter (see Optional Feature).
- perf_stall_cnt  out  32  buffer-full stall counter (see Optional Feature).

Behaviour:
- Reset state: pc = RESET_PC, count = 0, read and write pointers = 0, perf counters = 0.
  - Consequence: id_valid = 0 and imem_en = 0 while reset is high.
  - id_pc and id_instr show the head storage, which is don't-care while id_valid = 0.
- Reset applied mid-operation discards all buffered entries at that edge; no partial state survives.
- The FIFO holds {pc, instr} pairs. count has clog2(DEPTH+1) bits. Pointers wrap modulo DEPTH.
- id_valid = system_ena & ~redirect_valid & (count != 0). id_pc and id_instr come from the head entry.
- pop = id_valid & id_ready.
- can_push = (count < DEPTH) | pop.
  - Pass-through when full is allowed: a push and a pop in the same cycle leave count unchanged.
- imem_en = system_ena & ~redirect_valid & can_push.
- When imem_en = 1, on the clock edge:
  - push {pc, imem_rdata};
  - pc <= pc + 4, using 32-bit wrapping arithmetic (32'hFFFF_FFFC wraps to 32'h0).
- When pop = 1: read pointer advances. The count update is +1 for push only, -1 for pop only, and unchanged for both or neither.
- Redirect, when system_ena = 1 and redirect_valid = 1:
  - pc <= {redirect_pc[31:2], 2'b00}; count and both pointers are cleared.
  - There is no push and no pop that cycle.
  - Redirect has priority over every other event in that cycle.
- Redirect latency:
  - redirect asserted in cycle N;
  - imem_addr = target in N+1;
  - id_valid with id_pc = target in N+2.
- Back-to-back redirects: the last one wins. Each redirect restarts the N+2 latency.
- After reset deassertion in cycle N: imem_addr = RESET_PC in N, first id_valid in N+1.
- system_ena = 0: all state holds, id_valid = 0, imem_en = 0, and redirect_valid is ignored.
- Empty buffer: id_valid = 0, and id_ready has no effect.
- Full buffer with id_ready = 0: imem_en = 0, and the PC holds.
- The block never drops or duplicates an instruction outside a redirect.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- When defined:
  - perf_fetch_cnt increments on every push.
  - perf_stall_cnt increments on every cycle where system_ena = 1, redirect_valid = 0 and can_push = 0.
  - Both counters are 32-bit and wrap at 2^32. Both clear on reset and are not cleared by redirect.
- When undefined: both ports are driven constant 0 and no counter flops are synthesised.

Test Plan:
- Reset with RESET_PC = 0, imem preloaded with word i = 32'h1000_0000 + i, id_ready held 1, 6 cycles after reset -> id_valid = 1 from cycle 1 onward; id_pc sequence 0, 4, 8, 12, 16; id_instr matches the preloaded words; imem_en = 1 every cycle.
- id_ready = 0 for 5 cycles with DEPTH = 2 -> count saturates at 2, imem_addr holds at 8, imem_en = 0; perf_stall_cnt = 3 with FETCH_PERF_CNT_EN defined; on release, decode receives 0, 4, 8 in order with no gaps.
- Full buffer with id_ready = 1 -> pass-through: one push and one pop per cycle, count stays 2, and the PC advances by 4 each cycle.
- redirect_valid with redirect_pc = 32'h0000_0103 while 2 entries are buffered -> id_valid = 0 in N and N+1; id_pc = 32'h0000_0100 at N+2; the stale entries are never handed to decode.
- system_ena = 0 for 3 cycles mid-stream, with a redirect pulsed during the freeze -> no state change, id_valid = 0 throughout, the redirect is ignored; the sequence resumes at the held PC.
- Reset asserted while full, then PC forced near 32'hFFFF_FFF8 via redirect -> buffer is empty after the reset edge; the later fetch sequence runs FFF8, FFFC, 0000_0000, showing the PC wraps.
